// File: rtl/gb_oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source memory port,
// OAM write port and a debug view of the engine state.
interface gb_oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_data_o;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_i;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_o;
  logic        oam_wr;
  logic        dma_active;
  logic [1:0]  dbg_state;

  // Strobe semantics: cpu_wr/cpu_rd, mem_rd and oam_wr are single-cycle
  // qualifiers with no back-pressure; a strobe high at a rising edge is a
  // completed transfer, and mem_data_i is valid the cycle after mem_rd.
  modport master (
    output cpu_addr, cpu_data_i, cpu_wr, cpu_rd, mem_data_i,
    input  cpu_data_o, mem_addr, mem_rd, oam_addr, oam_data_o, oam_wr,
    input  dma_active, dbg_state
  );
  modport slave (
    input  cpu_addr, cpu_data_i, cpu_wr, cpu_rd, mem_data_i,
    output cpu_data_o, mem_addr, mem_rd, oam_addr, oam_data_o, oam_wr,
    output dma_active, dbg_state
  );
endinterface

// File: rtl/gb_oam_dma.sv
// Game Boy OAM DMA: a write to 0xFF46 copies 160 bytes from {src_hi, 0x00..0x9F}
// into OAM, one byte per 4 cycles after a 4-cycle setup.
module gb_oam_dma (
  input  logic          clk,
  input  logic          reset,
  gb_oam_dma_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  reg_dma_q, reg_dma_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  setup_q, setup_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;

  logic        reg_wr;
  logic [7:0]  src_hi;
  logic        mem_rd;
  logic        oam_wr;

  assign reg_wr = bus.cpu_wr && (bus.cpu_addr == 16'hFF46);
  // Pages 0xE0-0xFF mirror work RAM at 0xC0-0xDF.
  assign src_hi = (reg_dma_q >= 8'hE0) ? (reg_dma_q - 8'h20) : reg_dma_q;

  assign mem_rd = (state_q == S_XFER) && (phase_q == 2'd0);
  assign oam_wr = (state_q == S_XFER) && (phase_q == 2'd2);

  // Address/data outputs show the live value while strobed and hold it after.
  assign mem_addr_d = mem_rd ? {src_hi, byte_q} : mem_addr_q;
  assign oam_addr_d = oam_wr ? byte_q : oam_addr_q;
  assign oam_data_d = oam_wr ? data_q : oam_data_q;

  assign bus.mem_rd     = mem_rd;
  assign bus.oam_wr     = oam_wr;
  assign bus.mem_addr   = mem_addr_d;
  assign bus.oam_addr   = oam_addr_d;
  assign bus.oam_data_o = oam_data_d;
  assign bus.dma_active = (state_q != S_IDLE);
  assign bus.dbg_state  = state_q;
  assign bus.cpu_data_o = (bus.cpu_rd && (bus.cpu_addr == 16'hFF46)) ? reg_dma_q : 8'hFF;

  always_comb begin
    state_d   = state_q;
    reg_dma_d = reg_dma_q;
    byte_d    = byte_q;
    phase_d   = phase_q;
    setup_d   = setup_q;
    data_d    = data_q;
    case (state_q)
      S_IDLE: ;
      S_SETUP: begin
        if (setup_q == 2'd3) begin
          state_d = S_XFER;
          setup_d = 2'd0;
          byte_d  = 8'd0;
          phase_d = 2'd0;
        end else begin
          setup_d = setup_q + 2'd1;
        end
      end
      S_XFER: begin
        if (phase_q == 2'd1) data_d = bus.mem_data_i;
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (byte_q == 8'd159) begin
            state_d = S_IDLE;
            byte_d  = 8'd0;
          end else begin
            byte_d = byte_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A register write always wins: it restarts from SETUP, dropping the current byte.
    if (reg_wr) begin
      reg_dma_d = bus.cpu_data_i;
      state_d   = S_SETUP;
      byte_d    = 8'd0;
      phase_d   = 2'd0;
      setup_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      reg_dma_q  <= 8'hFF;
      byte_q     <= 8'd0;
      phase_q    <= 2'd0;
      setup_q    <= 2'd0;
      data_q     <= 8'd0;
      mem_addr_q <= 16'd0;
      oam_addr_q <= 8'd0;
      oam_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      reg_dma_q  <= reg_dma_d;
      byte_q     <= byte_d;
      phase_q    <= phase_d;
      setup_q    <= setup_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
    end
  end
endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: register decode table, directed restart/reset corners,
// and randomized transfers checked against a queue-based transfer model.
module tb_gb_oam_dma;
  logic clk;
  logic reset;
  gb_oam_dma_if ifc ();

  gb_oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];     // {oam_addr, oam_data}
  logic [31:0] exp_rd_q[$];  // source addresses

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // Reference model: a transfer of page v produces n_rd reads and n_wr OAM writes.
  task automatic push_xfer(input logic [7:0] v, input int n_wr, input int n_rd);
    logic [7:0] hi;
    hi = (v >= 8'hE0) ? v - 8'h20 : v;
    for (int k = 0; k < n_rd; k++) exp_rd_q.push_back({16'd0, hi, k[7:0]});
    for (int k = 0; k < n_wr; k++) exp_q.push_back({16'd0, k[7:0], mem_fn({hi, k[7:0]})});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    ifc.cpu_addr = a; ifc.cpu_data_i = d; ifc.cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    ifc.cpu_wr = 1'b0; ifc.cpu_addr = 16'h0000;
  endtask

  task automatic cpu_read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    ifc.cpu_addr = a; ifc.cpu_rd = 1'b1;
    #1;
    check(name, {24'd0, ifc.cpu_data_o}, {24'd0, exp});
    ifc.cpu_rd = 1'b0; ifc.cpu_addr = 16'h0000;
  endtask

  // Counts consecutive dma_active cycles starting from the current cycle.
  task automatic measure_active(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ifc.dma_active !== 1'b1) break;
      n++;
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_left"}, exp_q.size(), 0);
    check({name, "_rd_left"}, exp_rd_q.size(), 0);
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  // ---------------- memory responder + read scoreboard ----------------
  initial begin
    logic [15:0] a;
    logic [31:0] e;
    ifc.mem_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (ifc.mem_rd === 1'b1 && reset === 1'b0) begin
        a = ifc.mem_addr;
        e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 32'hFFFF_FFFF;
        check("mem_rd_addr", {16'd0, a}, e);
        @(posedge clk);
        #1 ifc.mem_data_i = mem_fn(a);
        @(posedge clk);
        #1 ifc.mem_data_i = ~mem_fn(a);
      end
    end
  end

  // ---------------- OAM write scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (ifc.oam_wr === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("oam_write", {16'd0, ifc.oam_addr, ifc.oam_data_o}, e);
    end
  end

  // ---------------- register decode table ----------------
  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        rd;
    logic [7:0]  din;
    logic [7:0]  exp_do;
    logic        exp_active;
  } vec_t;
  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [7:0] v;
    reset = 1'b1;
    ifc.cpu_addr = 16'h0000; ifc.cpu_data_i = 8'h00;
    ifc.cpu_wr = 1'b0; ifc.cpu_rd = 1'b0;

    vecs[0] = '{16'hFF46, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[1] = '{16'hFF47, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[2] = '{16'hFF45, 1'b1, 1'b0, 8'h12, 8'hFF, 1'b0};
    vecs[3] = '{16'hFF47, 1'b1, 1'b0, 8'h34, 8'hFF, 1'b0};
    vecs[4] = '{16'h7F46, 1'b1, 1'b0, 8'h56, 8'hFF, 1'b0};
    vecs[5] = '{16'hFF46, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[6] = '{16'hFF45, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0};

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #2;
    check("rst_active", ifc.dma_active, 0);
    check("rst_mem_rd", ifc.mem_rd, 0);
    check("rst_oam_wr", ifc.oam_wr, 0);
    check("rst_mem_addr", ifc.mem_addr, 0);
    check("rst_oam_addr", ifc.oam_addr, 0);
    check("rst_oam_data", ifc.oam_data_o, 0);
    check("rst_state", ifc.dbg_state, 0);
    cpu_read_check("rst_reg_dma", 16'hFF46, 8'hFF);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_release", ifc.dma_active, 0);

    // Register decode table
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      ifc.cpu_addr = vecs[i].addr; ifc.cpu_wr = vecs[i].wr;
      ifc.cpu_rd = vecs[i].rd; ifc.cpu_data_i = vecs[i].din;
      @(negedge clk);
      check($sformatf("vec%0d_cpu_data_o", i), ifc.cpu_data_o, vecs[i].exp_do);
      @(posedge clk);
      #1;
      ifc.cpu_wr = 1'b0; ifc.cpu_rd = 1'b0; ifc.cpu_addr = 16'h0000;
      #1;
      check($sformatf("vec%0d_active", i), ifc.dma_active, vecs[i].exp_active);
    end

    // Page 0xC1: setup timing, first read in cycle 5, 644 active cycles
    push_xfer(8'hC1, 160, 160);
    cpu_write(16'hFF46, 8'hC1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("setup%0d_active", i), ifc.dma_active, 1);
      check($sformatf("setup%0d_mem_rd", i), ifc.mem_rd, 0);
      check($sformatf("setup%0d_oam_wr", i), ifc.oam_wr, 0);
    end
    @(negedge clk);
    check("first_rd_cycle5", ifc.mem_rd, 1);
    check("first_rd_addr", ifc.mem_addr, 16'hC100);
    measure_active(n);
    check("c1_active_cycles", 5 + n, 644);
    check_drained("c1");

    // Page 0xE3 mirrors to 0xC3
    push_xfer(8'hE3, 160, 160);
    cpu_write(16'hFF46, 8'hE3);
    measure_active(n);
    check("e3_active_cycles", n, 644);
    check_drained("e3");
    #1;
    cpu_read_check("e3_reg_read", 16'hFF46, 8'hE3);

    // Restart at byte 50 phase 1
    push_xfer(8'h80, 50, 51);
    push_xfer(8'h90, 160, 160);
    cpu_write(16'hFF46, 8'h80);
    fork
      begin repeat (204) @(posedge clk); cpu_write(16'hFF46, 8'h90); end
      measure_active(n);
    join
    check("restart_active_cycles", n, 850);
    check_drained("restart");

    // Write coinciding with the final transfer cycle
    push_xfer(8'h12, 160, 160);
    push_xfer(8'h00, 160, 160);
    cpu_write(16'hFF46, 8'h12);
    fork
      begin repeat (642) @(posedge clk); cpu_write(16'hFF46, 8'h00); end
      measure_active(n);
    join
    check("final_cycle_active_cycles", n, 1288);
    check_drained("final_cycle");

    // Reset at byte 100, phase 0
    push_xfer(8'h45, 100, 100);
    cpu_write(16'hFF46, 8'h45);
    fork
      begin
        repeat (404) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_active", ifc.dma_active, 0);
        check("midrst_oam_wr", ifc.oam_wr, 0);
        check("midrst_mem_rd", ifc.mem_rd, 0);
        cpu_read_check("midrst_reg_dma", 16'hFF46, 8'hFF);
      end
      measure_active(n);
    join
    check("midrst_active_cycles", n, 404);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (ifc.dma_active === 1'b1) n++;
    end
    check("post_rst_idle_cycles", n, 0);
    check_drained("midrst");

    // Randomized transfers
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom_range(0, 255));
      push_xfer(v, 160, 160);
      if ($urandom_range(0, 1) == 1) cpu_write(16'hFF40 + 16'($urandom_range(0, 5)), 8'($urandom));
      cpu_write(16'hFF46, v);
      measure_active(n);
      check($sformatf("rand%0d_active_cycles", it), n, 644);
      check_drained($sformatf("rand%0d", it));
      #1;
      cpu_read_check($sformatf("rand%0d_reg_read", it), 16'hFF46, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gb_oam_dma.md
GB_OAM_DMA -- requirements
Module: gb_oam_dma

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system T-clock (~4 MHz); all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr  input  16  CPU address bus.
REQ-005 cpu_data_i  input  8  CPU write data.
REQ-006 cpu_wr  input  1  CPU write strobe, one cycle per write.
REQ-007 cpu_rd  input  1  CPU read strobe.
REQ-008 cpu_data_o  output  8  read data for 0xFF46.
REQ-009 mem_addr  output  16  source address to system memory.
REQ-010 mem_rd  output  1  source read request.
REQ-011 mem_data_i  input  8  source read data, valid the cycle after mem_rd is asserted.
REQ-012 oam_addr  output  8  OAM byte index, range 0x00-0x9F.
REQ-013 oam_data_o  output  8  OAM write data.
REQ-014 oam_wr  output  1  OAM write strobe, one-cycle pulse.
REQ-015 dma_active  output  1  transfer in progress; the CPU is restricted to HRAM while high.

Function
REQ-016 A register write SHALL occur when cpu_wr=1 and cpu_addr=0xFF46; the module latches cpu_data_i into reg_DMA and triggers a transfer.
REQ-017 cpu_data_o SHALL be combinational: reg_DMA when cpu_rd=1 and cpu_addr=0xFF46, else 0xFF.
REQ-018 The source high byte SHALL be reg_DMA for values 0x00-0xDF, and reg_DMA-0x20 for values 0xE0-0xFF (echo-RAM mirror).
REQ-019 The source address for byte i SHALL be {src_hi, i[7:0]}.
REQ-020 The FSM SHALL have three states: IDLE, SETUP and XFER.
REQ-021 IDLE->SETUP SHALL occur on the edge that accepts a register write.
REQ-022 SETUP SHALL last exactly 4 cycles, then go to XFER.
REQ-023 XFER->IDLE SHALL occur after byte 159, phase 3.
REQ-024 dma_active SHALL be 1 in SETUP and XFER and 0 in IDLE, giving 644 cycles total from trigger.
REQ-025 During SETUP there SHALL be no mem_rd and no oam_wr.
REQ-026 XFER SHALL use an 8-bit byte counter (0..159) and a 2-bit phase counter (0..3): one byte per 4 cycles, 640 cycles total.
REQ-027 Phase 0: mem_rd=1 and mem_addr=source address of byte i.
REQ-028 Phase 1: mem_data_i is captured into a data latch.
REQ-029 Phase 2: oam_wr=1, oam_addr=i, oam_data_o=latched byte.
REQ-030 Phase 3: idle; the byte counter increments on its exit edge.
REQ-031 mem_rd and oam_wr SHALL be 0 in all other phases and states; mem_addr and oam_addr hold their last values.
REQ-032 A register write during SETUP or XFER SHALL restart the transfer: reg_DMA updated, byte and phase counters cleared, state forced to SETUP on the next edge, dma_active held high, and any unissued OAM write of the current byte dropped.
REQ-033 A write to 0xFF46 coinciding with the final XFER cycle SHALL restart per REQ-032, with dma_active staying high.
REQ-034 The byte counter SHALL never exceed 159; oam_addr SHALL never exceed 0x9F.
REQ-035 Writes to addresses other than 0xFF46 SHALL be ignored.

Reset
REQ-036 While reset=1, state=IDLE, reg_DMA=0xFF, counters=0, data latch=0x00.
REQ-037 While reset=1, outputs SHALL be: dma_active=0, mem_rd=0, oam_wr=0, mem_addr=0x0000, oam_addr=0x00, oam_data_o=0x00.
REQ-038 Reset asserted mid-transfer SHALL abort immediately with no further OAM writes.
REQ-039 After release, the module SHALL remain IDLE until a register write.

Verification
REQ-040 Write 0xC1 -> dma_active high 644 cycles; 160 oam_wr pulses; pulse k at oam_addr=k with data from 0xC100+k; first mem_rd at cycle 5 after trigger.
REQ-041 Write 0xE3 -> mem_addr sequence 0xC300..0xC39F; cpu read of 0xFF46 returns 0xE3.
REQ-042 Write 0x80, then write 0x90 at byte 50, phase 1 -> no OAM write for byte 50 from 0x80xx; restart at oam_addr=0x00 from 0x9000 after 4 SETUP cycles.
REQ-043 Assert reset at byte 100 -> same-cycle outputs dma_active=0, oam_wr=0; reg_DMA reads 0xFF; no further writes after release.
REQ-044 Write 0x00 coincident with final XFER cycle -> dma_active never drops; new transfer from 0x0000 completes.
REQ-045 cpu_rd at 0xFF47 -> cpu_data_o=0xFF; write at 0xFF45 -> no transfer started.
